// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

  localparam int unsigned DSEL_W  = 32;
  localparam int unsigned ALIGN_W = 3;

  localparam logic [DSEL_W-1:0]  DSEL_NONE  = 32'h0;
  localparam logic [ALIGN_W-1:0] ALIGN_MASK = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT
  } mem_state_e;

  // Control bits carried from the EX->MEM register
  typedef struct packed {
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic blt;
    logic bge;
  } mem_ctrl_t;

  function automatic logic is_aligned(input logic [ALIGN_W-1:0] lsb);
    return (lsb & ALIGN_MASK) == ALIGN_W'(0);
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory req/ack handshake tracker; owns dmem_req and the pipeline stall.
module mem_access_fsm
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  input  logic ack,
  output logic req,
  output logic stall
);

  logic [0:0] state;
  logic [0:0] state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Request is held steady in both states until the memory acks
  always_comb begin
    state_nxt = state;
    req       = rst_n & issue & ((state == ST_IDLE) | (state == ST_WAIT));
    case (state)
      ST_IDLE: if (req && !ack) state_nxt = ST_WAIT;
      ST_WAIT: if (ack)         state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  assign stall = req & ~ack;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-memory handshake, branch resolution, MEM->WB register.
// Optional MEM_ALIGN_CHECK_EN suppresses misaligned accesses and adds the misalign flag.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      daddrbus,
  input  logic [DATA_W-1:0]      databus_in,
  input  logic [DSEL_W-1:0]      Dsel_MEM,
  input  logic                   LW_MEM,
  input  logic                   SW_MEM,
  input  logic                   BEQ_MEM,
  input  logic                   BNE_MEM,
  input  logic                   BLT_MEM,
  input  logic                   BGE_MEM,
  input  logic                   zcomp_MEM,
  input  logic                   nzcomp_MEM,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [ADDR_W-1:0]      dmem_addr,
  output logic [DATA_W-1:0]      dmem_wdata,
  input  logic [DATA_W-1:0]      dmem_rdata,
  input  logic                   dmem_ack,
  output logic                   mem_stall,
  output logic                   branch_taken,
  output logic [DSEL_W-1:0]      Dsel_WB,
  output logic [DATA_W-1:0]      wb_data,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                   misalign,
`endif
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  mem_ctrl_t ctrl;
  logic      load;
  logic      store;
  logic      access;
  logic      is_branch;
  logic      aligned;
  logic      issue;

  assign ctrl      = '{lw: LW_MEM, sw: SW_MEM, beq: BEQ_MEM,
                       bne: BNE_MEM, blt: BLT_MEM, bge: BGE_MEM};
  assign load      = ctrl.lw;
  assign store     = ctrl.sw & ~ctrl.lw;
  assign access    = ctrl.lw | ctrl.sw;
  assign is_branch = ctrl.beq | ctrl.bne | ctrl.blt | ctrl.bge;

`ifdef MEM_ALIGN_CHECK_EN
  assign aligned = is_aligned(daddrbus[ALIGN_W-1:0]);
`else
  assign aligned = 1'b1;
`endif

  assign issue = access & aligned;

  mem_access_fsm u_fsm (
    .clk   (clk),
    .rst_n (rst_n),
    .issue (issue),
    .ack   (dmem_ack),
    .req   (dmem_req),
    .stall (mem_stall)
  );

  assign dmem_we    = store;
  assign dmem_addr  = daddrbus;
  assign dmem_wdata = databus_in;

  // Branches resolve only once the stage is free to advance
  assign branch_taken = ~mem_stall &
                        (((ctrl.beq | ctrl.bge) & zcomp_MEM) |
                         ((ctrl.bne | ctrl.blt) & nzcomp_MEM));

  // Stores, branches and suppressed loads produce no writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Dsel_WB <= DSEL_NONE;
      wb_data <= '0;
    end else if (mem_stall) begin
      Dsel_WB <= DSEL_NONE;
    end else begin
      Dsel_WB <= (store | is_branch | (load & ~aligned)) ? DSEL_NONE : Dsel_MEM;
      wb_data <= load ? dmem_rdata : DATA_W'(daddrbus);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (mem_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else        misalign <= access & ~aligned;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [63:0] daddrbus;
  logic [63:0] databus_in;
  logic [31:0] Dsel_MEM;
  logic        LW_MEM, SW_MEM, BEQ_MEM, BNE_MEM, BLT_MEM, BGE_MEM;
  logic        zcomp_MEM, nzcomp_MEM;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall, branch_taken;
  logic [31:0] Dsel_WB;
  logic [63:0] wb_data;
  logic [31:0] stall_cycles;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int total;
  int bad;

  mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .daddrbus     (daddrbus),
    .databus_in   (databus_in),
    .Dsel_MEM     (Dsel_MEM),
    .LW_MEM       (LW_MEM),
    .SW_MEM       (SW_MEM),
    .BEQ_MEM      (BEQ_MEM),
    .BNE_MEM      (BNE_MEM),
    .BLT_MEM      (BLT_MEM),
    .BGE_MEM      (BGE_MEM),
    .zcomp_MEM    (zcomp_MEM),
    .nzcomp_MEM   (nzcomp_MEM),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .mem_stall    (mem_stall),
    .branch_taken (branch_taken),
    .Dsel_WB      (Dsel_WB),
    .wb_data      (wb_data),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign     (misalign),
`endif
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    daddrbus   = 64'h0;
    databus_in = 64'h0;
    Dsel_MEM   = 32'h0;
    LW_MEM     = 1'b0;
    SW_MEM     = 1'b0;
    BEQ_MEM    = 1'b0;
    BNE_MEM    = 1'b0;
    BLT_MEM    = 1'b0;
    BGE_MEM    = 1'b0;
    zcomp_MEM  = 1'b0;
    nzcomp_MEM = 1'b0;
    dmem_rdata = 64'h0;
    dmem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    LW_MEM   = 1'b1;
    daddrbus = 64'h10;
    repeat (2) @(negedge clk);
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", dmem_req); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", mem_stall); end
    total++; if (Dsel_WB !== 32'h0) begin bad++; $display("FAIL rst_dsel got=%h exp=0", Dsel_WB); end
    total++; if (wb_data !== 64'h0) begin bad++; $display("FAIL rst_wbdata got=%h exp=0", wb_data); end
    total++; if (stall_cycles !== 32'h0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", stall_cycles); end
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_wait_lw();
    LW_MEM = 1'b1; daddrbus = 64'h40; Dsel_MEM = 32'h4;
    dmem_ack = 1'b1; dmem_rdata = 64'hDEAD;
    #1;
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL zw_req got=%0h exp=1", dmem_req); end
    total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL zw_we got=%0h exp=0", dmem_we); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL zw_stall got=%0h exp=0", mem_stall); end
    total++; if (dmem_addr !== 64'h40) begin bad++; $display("FAIL zw_addr got=%h exp=40", dmem_addr); end
    @(negedge clk);
    total++; if (Dsel_WB !== 32'h4) begin bad++; $display("FAIL zw_dsel got=%h exp=4", Dsel_WB); end
    total++; if (wb_data !== 64'hDEAD) begin bad++; $display("FAIL zw_wbdata got=%h exp=dead", wb_data); end
    total++; if (dut.u_fsm.state !== ST_IDLE) begin bad++; $display("FAIL zw_state got=%0h exp=0", dut.u_fsm.state); end
    idle_inputs();
  endtask

  task automatic test_alu_op();
    daddrbus = 64'h7; Dsel_MEM = 32'h2;
    #1;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL alu_req got=%0h exp=0", dmem_req); end
    @(negedge clk);
    total++; if (Dsel_WB !== 32'h2) begin bad++; $display("FAIL alu_dsel got=%h exp=2", Dsel_WB); end
    total++; if (wb_data !== 64'h7) begin bad++; $display("FAIL alu_wbdata got=%h exp=7", wb_data); end
    idle_inputs();
  endtask

  task automatic test_sw_wait();
    SW_MEM = 1'b1; daddrbus = 64'h80; databus_in = 64'h1234_5678; Dsel_MEM = 32'h8;
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL sw_stall[%0d] got=%0h exp=1", i, mem_stall); end
      total++; if (dmem_we !== 1'b1) begin bad++; $display("FAIL sw_we[%0d] got=%0h exp=1", i, dmem_we); end
      total++; if (dmem_wdata !== 64'h1234_5678) begin bad++; $display("FAIL sw_wdata[%0d] got=%h exp=12345678", i, dmem_wdata); end
      @(negedge clk);
      total++; if (Dsel_WB !== 32'h0) begin bad++; $display("FAIL sw_bubble[%0d] got=%h exp=0", i, Dsel_WB); end
      total++; if (dut.u_fsm.state !== ST_WAIT) begin bad++; $display("FAIL sw_state[%0d] got=%0h exp=1", i, dut.u_fsm.state); end
    end
    dmem_ack = 1'b1;
    #1;
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL sw_ackstall got=%0h exp=0", mem_stall); end
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL sw_ackreq got=%0h exp=1", dmem_req); end
    @(negedge clk);
    total++; if (Dsel_WB !== 32'h0) begin bad++; $display("FAIL sw_dsel got=%h exp=0", Dsel_WB); end
    total++; if (wb_data !== 64'h80) begin bad++; $display("FAIL sw_wbdata got=%h exp=80", wb_data); end
    total++; if (stall_cycles !== 32'd3) begin bad++; $display("FAIL sw_cnt got=%0d exp=3", stall_cycles); end
    total++; if (dut.u_fsm.state !== ST_IDLE) begin bad++; $display("FAIL sw_endstate got=%0h exp=0", dut.u_fsm.state); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    LW_MEM = 1'b1; daddrbus = 64'h100; Dsel_MEM = 32'h10; dmem_ack = 1'b0;
    #1;
    total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL b2b_stall got=%0h exp=1", mem_stall); end
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 64'hAAAA;
    @(negedge clk);
    total++; if (Dsel_WB !== 32'h10) begin bad++; $display("FAIL b2b_dsel0 got=%h exp=10", Dsel_WB); end
    total++; if (wb_data !== 64'hAAAA) begin bad++; $display("FAIL b2b_wb0 got=%h exp=aaaa", wb_data); end
    daddrbus = 64'h108; Dsel_MEM = 32'h20; dmem_rdata = 64'hBBBB;
    #1;
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL b2b_req1 got=%0h exp=1", dmem_req); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL b2b_stall1 got=%0h exp=0", mem_stall); end
    @(negedge clk);
    total++; if (Dsel_WB !== 32'h20) begin bad++; $display("FAIL b2b_dsel1 got=%h exp=20", Dsel_WB); end
    total++; if (wb_data !== 64'hBBBB) begin bad++; $display("FAIL b2b_wb1 got=%h exp=bbbb", wb_data); end
    total++; if (stall_cycles !== 32'd4) begin bad++; $display("FAIL b2b_cnt got=%0d exp=4", stall_cycles); end
    idle_inputs();
  endtask

  task automatic test_branch();
    BNE_MEM = 1'b1; nzcomp_MEM = 1'b1; Dsel_MEM = 32'h4; daddrbus = 64'h5;
    #1;
    total++; if (branch_taken !== 1'b1) begin bad++; $display("FAIL bne_taken got=%0h exp=1", branch_taken); end
    @(negedge clk);
    total++; if (Dsel_WB !== 32'h0) begin bad++; $display("FAIL bne_dsel got=%h exp=0", Dsel_WB); end
    nzcomp_MEM = 1'b0;
    #1;
    total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL bne_nt got=%0h exp=0", branch_taken); end
    @(negedge clk);
    idle_inputs();
    BGE_MEM = 1'b1; zcomp_MEM = 1'b1;
    #1;
    total++; if (branch_taken !== 1'b1) begin bad++; $display("FAIL bge_taken got=%0h exp=1", branch_taken); end
    BGE_MEM = 1'b0; BLT_MEM = 1'b1; zcomp_MEM = 1'b1; nzcomp_MEM = 1'b0;
    #1;
    total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL blt_nt got=%0h exp=0", branch_taken); end
    BLT_MEM = 1'b0; BEQ_MEM = 1'b1; LW_MEM = 1'b1; daddrbus = 64'h200; dmem_ack = 1'b0;
    #1;
    total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL beq_stalled got=%0h exp=0", branch_taken); end
    dmem_ack = 1'b1;
    #1;
    total++; if (branch_taken !== 1'b1) begin bad++; $display("FAIL beq_acked got=%0h exp=1", branch_taken); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_ack_no_req();
    dmem_ack = 1'b1;
    #1;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL noreq_req got=%0h exp=0", dmem_req); end
    @(negedge clk);
    total++; if (stall_cycles !== 32'd4) begin bad++; $display("FAIL noreq_cnt got=%0d exp=4", stall_cycles); end
    total++; if (dut.u_fsm.state !== ST_IDLE) begin bad++; $display("FAIL noreq_state got=%0h exp=0", dut.u_fsm.state); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    LW_MEM = 1'b1; daddrbus = 64'h300; Dsel_MEM = 32'h40; dmem_ack = 1'b0;
    @(negedge clk);
    total++; if (dut.u_fsm.state !== ST_WAIT) begin bad++; $display("FAIL rmw_wait got=%0h exp=1", dut.u_fsm.state); end
    rst_n = 1'b0;
    #1;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rmw_req got=%0h exp=0", dmem_req); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL rmw_stall got=%0h exp=0", mem_stall); end
    total++; if (wb_data !== 64'h0) begin bad++; $display("FAIL rmw_wbdata got=%h exp=0", wb_data); end
    total++; if (stall_cycles !== 32'h0) begin bad++; $display("FAIL rmw_cnt got=%0d exp=0", stall_cycles); end
    total++; if (dut.u_fsm.state !== ST_IDLE) begin bad++; $display("FAIL rmw_state got=%0h exp=0", dut.u_fsm.state); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (dut.u_fsm.state !== ST_IDLE) begin bad++; $display("FAIL rmw_post got=%0h exp=0", dut.u_fsm.state); end
    total++; if (Dsel_WB !== 32'h0) begin bad++; $display("FAIL rmw_dsel got=%h exp=0", Dsel_WB); end
  endtask

  task automatic test_misaligned();
    LW_MEM = 1'b1; daddrbus = 64'h43; Dsel_MEM = 32'h4; dmem_rdata = 64'h55; dmem_ack = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    #1;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL mis_req got=%0h exp=0", dmem_req); end
    total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL mis_stall got=%0h exp=0", mem_stall); end
    @(negedge clk);
    total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_flag got=%0h exp=1", misalign); end
    total++; if (Dsel_WB !== 32'h0) begin bad++; $display("FAIL mis_dsel got=%h exp=0", Dsel_WB); end
    idle_inputs();
    @(negedge clk);
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL mis_clear got=%0h exp=0", misalign); end
`else
    dmem_ack = 1'b1;
    #1;
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL mis_req got=%0h exp=1", dmem_req); end
    total++; if (dmem_addr !== 64'h43) begin bad++; $display("FAIL mis_addr got=%h exp=43", dmem_addr); end
    @(negedge clk);
    total++; if (Dsel_WB !== 32'h4) begin bad++; $display("FAIL mis_dsel got=%h exp=4", Dsel_WB); end
    total++; if (wb_data !== 64'h55) begin bad++; $display("FAIL mis_wbdata got=%h exp=55", wb_data); end
    idle_inputs();
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_zero_wait_lw();
    test_alu_op();
    test_sw_wait();
    test_back_to_back();
    test_branch();
    test_ack_no_req();
    test_reset_mid_wait();
    test_misaligned();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
